// File: rtl/vrased_pkg.sv
// Shared definitions for the VRASED hardware monitors: FSM states, counter
// width, reset-handler entry point and protected memory region map.
package vrased_pkg;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        HOLD         = 2'd1,
        WAIT_HANDLER = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 8;

    localparam logic [15:0] RESET_HANDLER = 16'hFFFE;

    // Protected regions as seen by the per-property monitors
    localparam logic [15:0] SMEM_BASE  = 16'hA000;
    localparam logic [15:0] SMEM_SIZE  = 16'h4000;
    localparam logic [15:0] SDATA_BASE = 16'h0400;
    localparam logic [15:0] SDATA_SIZE = 16'h0C00;
    localparam logic [15:0] KMEM_BASE  = 16'h6A00;
    localparam logic [15:0] KMEM_SIZE  = 16'h0040;
    localparam logic [15:0] HMAC_BASE  = 16'h0230;
    localparam logic [15:0] HMAC_SIZE  = 16'h0020;

endpackage

// File: rtl/vrased_prio_enc.sv
// Lowest-index-first priority encoder; valid is high when any request bit is set.
module vrased_prio_enc #(
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (req[i] && !valid) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vrased_kill_seq.sv
// Central kill sequencer: turns monitor violations into a timed PUC request,
// keeps the key ROM locked until the CPU re-enters the reset handler.
module vrased_kill_seq #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned WAIT_MAX      = 64,
    parameter logic [15:0] RESET_HANDLER = vrased_pkg::RESET_HANDLER
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_SRC-1:0]         viol_req,
    input  logic [15:0]                pc,
    output logic                       puc_req,
    output logic                       key_lock,
    output logic [$clog2(NUM_SRC)-1:0] first_cause,
    output logic [NUM_SRC-1:0]         cause_all,
    output logic [7:0]                 viol_count,
    output logic [1:0]                 state_o
);

    import vrased_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_MAX - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               puc_q, puc_d;
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   first_q, first_d;
    logic [NUM_SRC-1:0] all_q, all_d;
    logic [7:0]         count_q, count_d;
    logic [7:0]         count_inc;

    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;

    vrased_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .req   (viol_req),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        all_d     = all_q;
        count_d   = count_q;
        count_inc = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;

        case (state_q)
            RUN: begin
                if (enc_valid) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    first_d = enc_idx;
                    all_d   = viol_req;
                    count_d = count_inc;
                end
            end
            HOLD: begin
                all_d = all_q | viol_req;
                if (cnt_q == '0) begin
                    state_d = WAIT_HANDLER;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_HANDLER: begin
                // A violation wins over a simultaneous handler re-entry
                if (enc_valid) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    all_d   = all_q | viol_req;
                    count_d = count_inc;
                end else if (pc == RESET_HANDLER) begin
                    state_d = RUN;
                end else if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    count_d = count_inc;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = HOLD_LOAD;
            end
        endcase

        puc_d  = (state_d == HOLD);
        lock_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            puc_q   <= 1'b0;
            lock_q  <= 1'b0;
            first_q <= '0;
            all_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            puc_q   <= puc_d;
            lock_q  <= lock_d;
            first_q <= first_d;
            all_q   <= all_d;
            count_q <= count_d;
        end
    end

    assign puc_req     = puc_q;
    assign key_lock    = lock_q;
    assign first_cause = first_q;
    assign cause_all   = all_q;
    assign viol_count  = count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_vrased_kill_seq.sv
// Directed bench for vrased_kill_seq: vector table for the main kill flow plus
// hand sequences for saturation and asynchronous reset.
module tb_vrased_kill_seq;

    logic        clk;
    logic        reset_n;
    logic [3:0]  viol_req;
    logic [15:0] pc;
    logic        puc_req;
    logic        key_lock;
    logic [1:0]  first_cause;
    logic [3:0]  cause_all;
    logic [7:0]  viol_count;
    logic [1:0]  state_o;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    vrased_kill_seq #(
        .NUM_SRC       (4),
        .HOLD_CYCLES   (16),
        .WAIT_MAX      (64),
        .RESET_HANDLER (16'hFFFE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .viol_req    (viol_req),
        .pc          (pc),
        .puc_req     (puc_req),
        .key_lock    (key_lock),
        .first_cause (first_cause),
        .cause_all   (cause_all),
        .viol_count  (viol_count),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  viol;
        logic [15:0] pc;
        int unsigned n;
        logic [1:0]  st;
        logic        puc;
        logic        lock;
        logic [1:0]  first;
        logic [3:0]  all;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [1:0] st, input logic puc,
                       input logic lock, input logic [1:0] first,
                       input logic [3:0] all, input logic [7:0] cnt);
        compared++;
        if (state_o !== st || puc_req !== puc || key_lock !== lock ||
            first_cause !== first || cause_all !== all || viol_count !== cnt) begin
            mismatched++;
            $display("FAIL %s: got st=%0d puc=%b lock=%b first=%0d all=%b cnt=%0d, expected st=%0d puc=%b lock=%b first=%0d all=%b cnt=%0d",
                     nm, state_o, puc_req, key_lock, first_cause, cause_all, viol_count,
                     st, puc, lock, first, all, cnt);
        end
    endtask

    initial begin
        //             name            viol     pc        n   st  puc lock first all      cnt
        vecs[0]  = '{"idle",          4'b0000, 16'hE000, 20, 2'd0, 0, 0, 2'd0, 4'b0000, 8'd0};
        vecs[1]  = '{"kill_src2",     4'b0100, 16'hE000, 1,  2'd1, 1, 1, 2'd2, 4'b0100, 8'd1};
        vecs[2]  = '{"hold_last",     4'b0000, 16'hE000, 15, 2'd1, 1, 1, 2'd2, 4'b0100, 8'd1};
        vecs[3]  = '{"enter_wait",    4'b0000, 16'hE000, 1,  2'd2, 0, 1, 2'd2, 4'b0100, 8'd1};
        vecs[4]  = '{"release",       4'b0000, 16'hFFFE, 1,  2'd0, 0, 0, 2'd2, 4'b0100, 8'd1};
        vecs[5]  = '{"kill_1010",     4'b1010, 16'hE000, 1,  2'd1, 1, 1, 2'd1, 4'b1010, 8'd2};
        vecs[6]  = '{"hold_mid",      4'b0000, 16'hE000, 4,  2'd1, 1, 1, 2'd1, 4'b1010, 8'd2};
        vecs[7]  = '{"merge_0100",    4'b0100, 16'hE000, 1,  2'd1, 1, 1, 2'd1, 4'b1110, 8'd2};
        vecs[8]  = '{"no_restart",    4'b0000, 16'hE000, 10, 2'd1, 1, 1, 2'd1, 4'b1110, 8'd2};
        vecs[9]  = '{"wait_2",        4'b0000, 16'hE000, 1,  2'd2, 0, 1, 2'd1, 4'b1110, 8'd2};
        vecs[10] = '{"viol_vs_pc",    4'b0001, 16'hFFFE, 1,  2'd1, 1, 1, 2'd1, 4'b1111, 8'd3};
        vecs[11] = '{"rekill_hold",   4'b0000, 16'hE000, 15, 2'd1, 1, 1, 2'd1, 4'b1111, 8'd3};
        vecs[12] = '{"wait_3",        4'b0000, 16'hE000, 1,  2'd2, 0, 1, 2'd1, 4'b1111, 8'd3};
        vecs[13] = '{"wait_to_edge",  4'b0000, 16'h4000, 63, 2'd2, 0, 1, 2'd1, 4'b1111, 8'd3};
        vecs[14] = '{"timeout",       4'b0000, 16'h4000, 1,  2'd1, 1, 1, 2'd1, 4'b1111, 8'd4};

        reset_n  = 1'b0;
        viol_req = '0;
        pc       = 16'hE000;
        #3;
        chk("reset_state", 2'd0, 0, 0, 2'd0, 4'b0000, 8'd0);
        tick(2);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            viol_req = vecs[i].viol;
            pc       = vecs[i].pc;
            tick(vecs[i].n);
            chk(vecs[i].name, vecs[i].st, vecs[i].puc, vecs[i].lock,
                vecs[i].first, vecs[i].all, vecs[i].cnt);
        end

        // Finish the timeout kill and release
        viol_req = '0;
        pc       = 16'hE000;
        tick(16);
        chk("wait_4", 2'd2, 0, 1, 2'd1, 4'b1111, 8'd4);
        pc = 16'hFFFE;
        tick(1);
        chk("release_2", 2'd0, 0, 0, 2'd1, 4'b1111, 8'd4);

        // Continuous violation: a kill from RUN overwrites causes, then one kill per 17 cycles
        pc       = 16'hE000;
        viol_req = 4'b0001;
        tick(1);
        chk("kill_overwrite", 2'd1, 1, 1, 2'd0, 4'b0001, 8'd5);
        tick(17 * 100);
        chk("count_105", 2'd1, 1, 1, 2'd0, 4'b0001, 8'd105);
        tick(17 * 200);
        chk("count_sat", 2'd1, 1, 1, 2'd0, 4'b0001, 8'd255);
        tick(17);
        chk("count_no_wrap", 2'd1, 1, 1, 2'd0, 4'b0001, 8'd255);

        // Asynchronous reset in the middle of HOLD
        viol_req = '0;
        tick(3);
        chk("pre_reset_hold", 2'd1, 1, 1, 2'd0, 4'b0001, 8'd255);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 2'd0, 0, 0, 2'd0, 4'b0000, 8'd0);
        tick(1);
        chk("reset_held", 2'd0, 0, 0, 2'd0, 4'b0000, 8'd0);
        reset_n = 1'b1;
        tick(2);
        chk("after_reset", 2'd0, 0, 0, 2'd0, 4'b0000, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
